multi_clk_div: RTL and testbench



---
 rtl/pwm_pkg.sv | 16 +
 rtl/clk_div_chan.sv | 80 ++++++++
 rtl/multi_clk_div.sv | 46 ++++
 tb/tb_multi_clk_div.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM clock-divider family.
//   DIV_BYPASS_MAX : largest divisor treated as pass-through (0 and 1 bypass)
//   DEFAULT_WIDTH  : default divisor / counter width
//   div_out_t      : the three registered per-channel outputs
package pwm_pkg;

  localparam int DIV_BYPASS_MAX = 1;
  localparam int DEFAULT_WIDTH  = 16;

  typedef struct packed {
    logic div_clk;
    logic tick;
    logic bypass;
  } div_out_t;

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, shadow divisor and three output flops.
// Ports:
//   i_wb_clk, i_wb_rst_n : clock, async active-low reset
//   i_en                 : channel enable (level)
//   i_sync               : one-cycle restart pulse
//   i_divisor            : requested divisor (sampled only at period boundaries)
//   o_div_clk            : divided-clock level (low phase >= high phase)
//   o_tick               : high on the last cycle of each period
//   o_bypass             : high while the active divisor is 0 or 1
module clk_div_chan
  import pwm_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             i_wb_clk,
  input  logic             i_wb_rst_n,
  input  logic             i_en,
  input  logic             i_sync,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_div_clk,
  output logic             o_tick,
  output logic             o_bypass
);

  localparam logic [WIDTH-1:0] BYP_MAX = WIDTH'(DIV_BYPASS_MAX);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic [WIDTH-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] d_act, d_nxt;
  logic             en_q;
  logic             load, end_per, byp_cur, byp_nxt;
  div_out_t         out_q, out_nxt;

  // ceil(d/2) without widening: (d>>1) never exceeds 2^(WIDTH-1)-1, so +1 fits
  function automatic logic [WIDTH-1:0] ceil_half(input logic [WIDTH-1:0] d);
    return (d >> 1) + {{(WIDTH-1){1'b0}}, d[0]};
  endfunction

  // Outputs are registered from the *next* counter/divisor state, so the
  // flops always describe the cycle index currently held in cnt.
  always_comb begin
    load    = i_sync | ~en_q;
    byp_cur = (d_act <= BYP_MAX);
    // d_act >= 2 whenever the compare matters, so d_act-1 cannot underflow
    end_per = byp_cur | (cnt == d_act - ONE);

    if (!i_en || load || end_per) begin
      // restart, period boundary, or idle: pick up the requested divisor
      cnt_nxt = '0;
      d_nxt   = i_divisor;
    end else begin
      cnt_nxt = cnt + ONE;
      d_nxt   = d_act;
    end

    byp_nxt         = (d_nxt <= BYP_MAX);
    out_nxt.bypass  = i_en & byp_nxt;
    out_nxt.tick    = i_en & (byp_nxt | (cnt_nxt == d_nxt - ONE));
    out_nxt.div_clk = i_en & ~byp_nxt & (cnt_nxt >= ceil_half(d_nxt));
  end

  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      cnt   <= '0;
      d_act <= '0;
      en_q  <= 1'b0;
      out_q <= '0;
    end else begin
      cnt   <= cnt_nxt;
      d_act <= d_nxt;
      en_q  <= i_en;
      out_q <= out_nxt;
    end
  end

  assign o_div_clk = out_q.div_clk;
  assign o_tick    = out_q.tick;
  assign o_bypass  = out_q.bypass;

endmodule

// File: rtl/multi_clk_div.sv
// Multi-channel clock divider. Every output is a flop on i_wb_clk; no
// derived clocks are produced.
// Ports:
//   i_wb_clk, i_wb_rst_n : clock, async active-low reset
//   i_en      [N_CH]        : per-channel enable
//   i_divisor [N_CH*WIDTH]  : channel c at [c*WIDTH +: WIDTH]
//   i_sync                  : restart all enabled channels at k=0
//   o_div_clk [N_CH]        : divided-clock levels
//   o_tick    [N_CH]        : end-of-period pulses
//   o_bypass  [N_CH]        : divisor 0/1 indication
module multi_clk_div
  import pwm_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                  i_wb_clk,
  input  logic                  i_wb_rst_n,
  input  logic [N_CH-1:0]       i_en,
  input  logic [N_CH*WIDTH-1:0] i_divisor,
  input  logic                  i_sync,
  output logic [N_CH-1:0]       o_div_clk,
  output logic [N_CH-1:0]       o_tick,
  output logic [N_CH-1:0]       o_bypass
);

  logic [N_CH-1:0][WIDTH-1:0] div_lane;

  assign div_lane = i_divisor;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    clk_div_chan #(
      .WIDTH (WIDTH)
    ) u_chan (
      .i_wb_clk   (i_wb_clk),
      .i_wb_rst_n (i_wb_rst_n),
      .i_en       (i_en[c]),
      .i_sync     (i_sync),
      .i_divisor  (div_lane[c]),
      .o_div_clk  (o_div_clk[c]),
      .o_tick     (o_tick[c]),
      .o_bypass   (o_bypass[c])
    );
  end

endmodule

// File: tb/tb_multi_clk_div.sv
// Directed bench for multi_clk_div (N_CH=4, WIDTH=16). Expected output
// sequences are hand-written bit patterns, bit i = i-th cycle after the
// stimulus edge.
module tb_multi_clk_div;

  localparam int N  = 4;
  localparam int W  = 16;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   en;
  logic [N*W-1:0] div;
  logic           sync;
  logic [N-1:0]   div_clk, tick, bypass;

  int n_cmp = 0;
  int n_err = 0;

  multi_clk_div #(.N_CH(N), .WIDTH(W)) dut (
    .i_wb_clk   (clk),
    .i_wb_rst_n (rst_n),
    .i_en       (en),
    .i_divisor  (div),
    .i_sync     (sync),
    .o_div_clk  (div_clk),
    .o_tick     (tick),
    .o_bypass   (bypass)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // advance one edge, then compare all three buses
  task automatic cyc(input string tag, input logic [N-1:0] ec, input logic [N-1:0] et,
                     input logic [N-1:0] eb);
    @(posedge clk); #1;
    chk({tag, " clk"},  32'(div_clk), 32'(ec));
    chk({tag, " tick"}, 32'(tick),    32'(et));
    chk({tag, " byp"},  32'(bypass),  32'(eb));
  endtask

  task automatic set_div(input int ch, input int v);
    div[ch*W +: W] = W'(v);
  endtask

  // run n cycles of a single channel against its clk/tick patterns
  task automatic run_ch(input string tag, input int ch, input int n,
                        input logic [31:0] cp, input logic [31:0] tp);
    for (int i = 0; i < n; i++)
      cyc(tag, N'(cp[i]) << ch, N'(tp[i]) << ch, '0);
  endtask

  initial begin
    logic [31:0] c0, t0, c1, t1;
    rst_n = 1'b0; en = '0; div = '0; sync = 1'b0;

    // reset state
    #3;
    chk("rst clk", 32'(div_clk), 0);
    chk("rst tick", 32'(tick), 0);
    chk("rst byp", 32'(bypass), 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst hold clk", 32'(div_clk), 0);
    rst_n = 1'b1;

    // div=4 on ch0: 0,0,1,1 with tick on the second high cycle
    set_div(0, 4); en = 4'b0001;
    run_ch("div4", 0, 8, 32'h0CC, 32'h088);
    en = '0;
    cyc("div4 off", '0, '0, '0);

    // div=5 on ch1: low 3, high 2
    set_div(1, 5); en = 4'b0010;
    run_ch("div5", 1, 10, 32'h318, 32'h210);
    en = '0;
    cyc("div5 off", '0, '0, '0);

    // div=2 on ch3: alternating
    set_div(3, 2); en = 4'b1000;
    run_ch("div2", 3, 6, 32'h02A, 32'h02A);
    en = '0;
    cyc("div2 off", '0, '0, '0);

    // ch2 div=6, request 3 at k=2: the 6-cycle period completes first
    set_div(2, 6); en = 4'b0100;
    run_ch("chg a", 2, 3, 32'h000, 32'h000);
    set_div(2, 3);
    run_ch("chg b", 2, 9, 32'h127, 32'h124);
    en = '0;
    cyc("chg off", '0, '0, '0);

    // ch0 div=4 and ch1 div=6 out of phase, then sync aligns them
    set_div(0, 4); set_div(1, 6); set_div(2, 0); set_div(3, 0);
    en = 4'b0001;
    @(posedge clk); #1;
    en = 4'b0011;
    repeat (3) @(posedge clk);
    #1;
    sync = 1'b1;
    c0 = 32'hCCC; t0 = 32'h888; c1 = 32'hE38; t1 = 32'h820;
    for (int i = 0; i < 12; i++) begin
      cyc("sync", {2'b00, c1[i], c0[i]}, {2'b00, t1[i], t0[i]}, '0);
      sync = 1'b0;
    end
    en = '0;
    cyc("sync off", '0, '0, '0);

    // bypass: div 0, then 1, then leave bypass with div 3
    set_div(3, 0); en = 4'b1000;
    repeat (3) cyc("byp0", '0, 4'b1000, 4'b1000);
    set_div(3, 1);
    repeat (2) cyc("byp1", '0, 4'b1000, 4'b1000);
    set_div(3, 3);
    cyc("byp->3 k0", '0, '0, '0);
    cyc("byp->3 k1", '0, '0, '0);
    cyc("byp->3 k2", 4'b1000, 4'b1000, '0);
    set_div(3, 0);
    cyc("byp->0", '0, 4'b1000, 4'b1000);
    en = '0;
    cyc("byp off", '0, '0, '0);

    // async reset mid-period, then a clean div=3 start
    set_div(0, 5); en = 4'b0001;
    run_ch("pre rst", 0, 4, 32'h8, 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst clk", 32'(div_clk), 0);
    chk("async rst tick", 32'(tick), 0);
    chk("async rst byp", 32'(bypass), 0);
    en = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    set_div(0, 3); en = 4'b0001;
    run_ch("post rst div3", 0, 6, 32'h24, 32'h24);
    en = '0;
    cyc("end off", '0, '0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
